// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - Bundle of requester and physical-memory signals for mem_arbiter
//
// Purpose: groups the instruction port, data port and physical memory port of
//          the arbiter into one interface.
// Modports:
//   slave  - arbiter view: requests and pmem completion in; responses and pmem command out.
//   master - environment view: drives requests and pmem completion, observes the rest.
// Signals:
//   instr_read, instr_mem_address[31:0]                    fetch request
//   instr_mem_resp, instr_mem_rdata[31:0]                  fetch completion
//   data_read, data_write, data_mbe[3:0],
//   data_mem_address[31:0], data_mem_wdata[31:0]           data request
//   data_mem_resp, data_mem_rdata[31:0]                    data completion
//   pmem_read, pmem_write, pmem_address[31:0],
//   pmem_wdata[63:0], pmem_byte_en[7:0]                    physical memory command
//   pmem_resp, pmem_rdata[63:0]                            physical memory completion
interface mem_arbiter_if;
    logic        instr_read;
    logic [31:0] instr_mem_address;
    logic        instr_mem_resp;
    logic [31:0] instr_mem_rdata;

    logic        data_read;
    logic        data_write;
    logic [3:0]  data_mbe;
    logic [31:0] data_mem_address;
    logic [31:0] data_mem_wdata;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;

    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic [7:0]  pmem_byte_en;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;

    modport slave (
        input  instr_read, instr_mem_address,
        output instr_mem_resp, instr_mem_rdata,
        input  data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        output data_mem_resp, data_mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_en,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output instr_read, instr_mem_address,
        input  instr_mem_resp, instr_mem_rdata,
        output data_read, data_write, data_mbe, data_mem_address, data_mem_wdata,
        input  data_mem_resp, data_mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_en,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - Two-port (fetch/data) arbiter onto a 64-bit physical memory
//
// Purpose: serves one 32-bit fetch port and one 32-bit data port from a single
//          64-bit physical memory, one access at a time. All outputs are registered.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - mem_arbiter_if.slave (requester ports and pmem port)
// Configuration:
//   MEM_ARBITER_ROUND_ROBIN_EN - defined: ties alternate between ports (first tie
//                                after reset goes to data); undefined: data always
//                                wins a tie.
module mem_arbiter (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    state_t      state_q;
    logic        pmem_read_q;
    logic        pmem_write_q;
    logic [31:0] pmem_address_q;
    logic [63:0] pmem_wdata_q;
    logic [7:0]  pmem_byte_en_q;
    logic        hi_q;            // selects the 32-bit half of the returned line
    logic        instr_resp_q;
    logic        data_resp_q;
    logic [31:0] instr_rdata_q;
    logic [31:0] data_rdata_q;

    logic        data_req;
    logic        grant_data_d;
    logic        grant_any_d;
    logic        cmd_write_d;
    logic [31:0] cmd_addr_d;
    logic [63:0] cmd_wdata_d;
    logic [7:0]  cmd_byte_en_d;
    logic [31:0] rdata_half_d;

    assign data_req = bus.data_read | bus.data_write;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_data_q;            // 1 when the most recent grant went to the data port
    assign grant_data_d = data_req & ~(bus.instr_read & last_data_q);
`else
    assign grant_data_d = data_req;
`endif

    assign grant_any_d = data_req | bus.instr_read;
    // A simultaneous read+write on the data port is a write.
    assign cmd_write_d = grant_data_d & bus.data_write;
    assign cmd_addr_d  = grant_data_d ? bus.data_mem_address : bus.instr_mem_address;
    assign cmd_wdata_d = cmd_write_d ? {bus.data_mem_wdata, bus.data_mem_wdata} : 64'h0;

    always_comb begin
        cmd_byte_en_d = 8'h00;
        if (cmd_write_d) begin
            cmd_byte_en_d = cmd_addr_d[2] ? {bus.data_mbe, 4'h0} : {4'h0, bus.data_mbe};
        end
    end

    assign rdata_half_d = hi_q ? bus.pmem_rdata[63:32] : bus.pmem_rdata[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= 32'h0;
            pmem_wdata_q   <= 64'h0;
            pmem_byte_en_q <= 8'h00;
            hi_q           <= 1'b0;
            instr_resp_q   <= 1'b0;
            data_resp_q    <= 1'b0;
            instr_rdata_q  <= 32'h0;
            data_rdata_q   <= 32'h0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_data_q    <= 1'b0;
`endif
        end else begin
            // Response strobes are single-cycle; they are re-asserted only on a completion edge.
            instr_resp_q <= 1'b0;
            data_resp_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_any_d) begin
                        state_q        <= grant_data_d ? BUSY_D : BUSY_I;
                        pmem_read_q    <= ~cmd_write_d;
                        pmem_write_q   <= cmd_write_d;
                        pmem_address_q <= cmd_addr_d & ~32'h7;
                        pmem_wdata_q   <= cmd_wdata_d;
                        pmem_byte_en_q <= cmd_byte_en_d;
                        hi_q           <= cmd_addr_d[2];
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                        last_data_q    <= grant_data_d;
`endif
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Command stays stable here; requester inputs are not looked at.
                    if (bus.pmem_resp) begin
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        if (state_q == BUSY_I) begin
                            instr_rdata_q <= rdata_half_d;
                            instr_resp_q  <= 1'b1;
                            state_q       <= DONE_I;
                        end else begin
                            data_rdata_q  <= rdata_half_d;
                            data_resp_q   <= 1'b1;
                            state_q       <= DONE_D;
                        end
                    end
                end
                DONE_I, DONE_D: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read       = pmem_read_q;
    assign bus.pmem_write      = pmem_write_q;
    assign bus.pmem_address    = pmem_address_q;
    assign bus.pmem_wdata      = pmem_wdata_q;
    assign bus.pmem_byte_en    = pmem_byte_en_q;
    assign bus.instr_mem_resp  = instr_resp_q;
    assign bus.instr_mem_rdata = instr_rdata_q;
    assign bus.data_mem_resp   = data_resp_q;
    assign bus.data_mem_rdata  = data_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - Self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- physical memory responder ----------------
    int          mem_wait = 0;      // busy cycles before pmem_resp
    bit          mem_hold = 1'b0;   // suppress pmem_resp entirely
    logic [63:0] mem_word = 64'h0;
    int          mem_cnt  = 0;

    always @(negedge clk) begin
        if (rst && !mem_hold && (bus.pmem_read || bus.pmem_write)) begin
            if (mem_cnt >= mem_wait) begin
                bus.pmem_resp = 1'b1;
            end else begin
                bus.pmem_resp = 1'b0;
                mem_cnt++;
            end
        end else begin
            bus.pmem_resp = 1'b0;
            mem_cnt = 0;
        end
        bus.pmem_rdata = mem_word;
    end

    // ---------------- behavioural model ----------------
    // Phase: 0 = free, 1 = access outstanding, 2 = completion cycle.
    int          m_phase;
    bit          m_data, m_write, m_hi, m_last_data;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_be;
    logic [31:0] m_irdata, m_drdata;

    logic m_dreq, m_pick_data;
    assign m_dreq      = bus.data_read | bus.data_write;
    // Data wins unless both ask and round-robin says data was served last.
    assign m_pick_data = m_dreq && !(bus.instr_read && RR && m_last_data);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0; m_data <= 0; m_write <= 0; m_hi <= 0; m_last_data <= 0;
            m_addr <= 0; m_wdata <= 0; m_be <= 0; m_irdata <= 0; m_drdata <= 0;
        end else if (m_phase == 0) begin
            if (m_dreq || bus.instr_read) begin
                m_phase     <= 1;
                m_data      <= m_pick_data;
                m_last_data <= m_pick_data;
                m_write     <= m_pick_data && bus.data_write;
                m_addr      <= (m_pick_data ? bus.data_mem_address : bus.instr_mem_address) & ~32'h7;
                m_hi        <= (m_pick_data ? bus.data_mem_address[2] : bus.instr_mem_address[2]);
                m_wdata     <= (m_pick_data && bus.data_write) ? {bus.data_mem_wdata, bus.data_mem_wdata} : 64'h0;
                m_be        <= (m_pick_data && bus.data_write)
                               ? (8'({4'h0, bus.data_mbe}) << (bus.data_mem_address[2] ? 4 : 0)) : 8'h00;
            end
        end else if (m_phase == 1) begin
            if (bus.pmem_resp) begin
                if (m_data) m_drdata <= 32'(bus.pmem_rdata >> (m_hi ? 32 : 0));
                else        m_irdata <= 32'(bus.pmem_rdata >> (m_hi ? 32 : 0));
                m_phase <= 2;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("m_instr_resp", 64'(bus.instr_mem_resp), 64'(m_phase == 2 && !m_data));
        chk("m_data_resp",  64'(bus.data_mem_resp),  64'(m_phase == 2 && m_data));
        chk("m_instr_rdata", 64'(bus.instr_mem_rdata), 64'(m_irdata));
        chk("m_data_rdata",  64'(bus.data_mem_rdata),  64'(m_drdata));
        chk("m_pmem_read",  64'(bus.pmem_read),  64'(m_phase == 1 && !m_write));
        chk("m_pmem_write", 64'(bus.pmem_write), 64'(m_phase == 1 && m_write));
        if (m_phase == 1 || !rst) begin
            chk("m_pmem_address", 64'(bus.pmem_address), 64'(m_addr));
            chk("m_pmem_byte_en", 64'(bus.pmem_byte_en), 64'(m_be));
            if (m_write || !rst) chk("m_pmem_wdata", bus.pmem_wdata, m_wdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_pulse(input bit is_data, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = is_data ? bus.data_mem_resp : bus.instr_mem_resp;
        end
        chk(name, 64'(seen), 64'd1);
    endtask

    int order[$];

    initial begin
        bus.instr_read = 0; bus.instr_mem_address = 0;
        bus.data_read = 0; bus.data_write = 0; bus.data_mbe = 0;
        bus.data_mem_address = 0; bus.data_mem_wdata = 0;
        bus.pmem_resp = 0; bus.pmem_rdata = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pmem_read", 64'(bus.pmem_read), 64'd0);
        chk("rst_pmem_address", 64'(bus.pmem_address), 64'd0);
        chk("rst_instr_rdata", 64'(bus.instr_mem_rdata), 64'd0);
        rst = 1'b1;

        // Zero-wait fetch from 0x44: upper half, resp at N+2
        @(negedge clk);
        mem_wait = 0; mem_word = 64'hAAAA_BBBB_CCCC_DDDD;
        bus.instr_mem_address = 32'h0000_0044; bus.instr_read = 1;
        @(negedge clk);
        chk("fetch_pmem_read", 64'(bus.pmem_read), 64'd1);
        chk("fetch_pmem_address", 64'(bus.pmem_address), 64'h40);
        chk("fetch_byte_en", 64'(bus.pmem_byte_en), 64'h00);
        chk("fetch_resp_early", 64'(bus.instr_mem_resp), 64'd0);
        @(negedge clk);
        chk("fetch_resp", 64'(bus.instr_mem_resp), 64'd1);
        chk("fetch_rdata", 64'(bus.instr_mem_rdata), 64'hAAAA_BBBB);
        bus.instr_read = 0;
        @(negedge clk);
        chk("fetch_resp_single", 64'(bus.instr_mem_resp), 64'd0);
        chk("fetch_rdata_hold", 64'(bus.instr_mem_rdata), 64'hAAAA_BBBB);

        // Data write, lower word
        mem_word = 64'h0;
        bus.data_mem_address = 32'h10; bus.data_mem_wdata = 32'h1234_5678;
        bus.data_mbe = 4'b0011; bus.data_write = 1;
        @(negedge clk);
        chk("wr_pmem_write", 64'(bus.pmem_write), 64'd1);
        chk("wr_pmem_read", 64'(bus.pmem_read), 64'd0);
        chk("wr_pmem_address", 64'(bus.pmem_address), 64'h10);
        chk("wr_pmem_wdata", bus.pmem_wdata, 64'h1234_5678_1234_5678);
        chk("wr_byte_en", 64'(bus.pmem_byte_en), 64'h03);
        @(negedge clk);
        chk("wr_resp", 64'(bus.data_mem_resp), 64'd1);
        bus.data_write = 0;
        @(negedge clk);

        // Read+write together on the upper word with low address bits set: a write
        mem_wait = 2;
        bus.data_mem_address = 32'h17; bus.data_mem_wdata = 32'hCAFE_F00D;
        bus.data_mbe = 4'b1010; bus.data_write = 1; bus.data_read = 1;
        @(negedge clk);
        chk("wr2_pmem_write", 64'(bus.pmem_write), 64'd1);
        chk("wr2_pmem_address", 64'(bus.pmem_address), 64'h10);
        chk("wr2_byte_en", 64'(bus.pmem_byte_en), 64'hA0);
        wait_pulse(1'b1, "wr2_resp");
        bus.data_write = 0; bus.data_read = 0;
        @(negedge clk);

        // Data read, upper word, 3-cycle memory
        mem_wait = 3; mem_word = 64'h1111_2222_3333_4444;
        bus.data_mem_address = 32'h104; bus.data_read = 1;
        wait_pulse(1'b1, "rd_resp");
        chk("rd_rdata", 64'(bus.data_mem_rdata), 64'h1111_2222);
        bus.data_read = 0;
        @(negedge clk);

        // Stalled memory: 10 stable cycles, then a single pulse
        mem_hold = 1; mem_wait = 0; mem_word = 64'h5555_6666_7777_8888;
        bus.instr_mem_address = 32'h8; bus.instr_read = 1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("stall_pmem_read", 64'(bus.pmem_read), 64'd1);
            chk("stall_pmem_address", 64'(bus.pmem_address), 64'h8);
            chk("stall_no_resp", 64'(bus.instr_mem_resp), 64'd0);
            if (i < 9) @(negedge clk);
        end
        #2 mem_hold = 0;
        @(negedge clk);
        chk("stall_resp_late", 64'(bus.instr_mem_resp), 64'd0);
        @(negedge clk);
        chk("stall_resp", 64'(bus.instr_mem_resp), 64'd1);
        chk("stall_rdata", 64'(bus.instr_mem_rdata), 64'h7777_8888);
        bus.instr_read = 0;
        @(negedge clk);
        chk("stall_resp_single", 64'(bus.instr_mem_resp), 64'd0);

        // Both requesting continuously, last grant was a fetch
        mem_wait = 1; mem_word = 64'h0BAD_0BAD_0600_D600;
        bus.instr_mem_address = 32'h200; bus.data_mem_address = 32'h300;
        bus.instr_read = 1; bus.data_read = 1;
        order.delete();
        for (int k = 0; k < 100 && order.size() < 4; k++) begin
            @(negedge clk);
            if (bus.data_mem_resp)  order.push_back(1);
            if (bus.instr_mem_resp) order.push_back(0);
        end
        bus.instr_read = 0; bus.data_read = 0;
        chk("tie_count", 64'(order.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            int want;
            want = RR ? ((k % 2 == 0) ? 1 : 0) : 1;
            chk("tie_order", 64'(order.size() > k ? order[k] : 9), 64'(want));
        end
        repeat (3) @(negedge clk);

        // Tie with the data requester dropping after its completion
        bus.instr_read = 1; bus.data_read = 1;
        wait_pulse(1'b1, "drop_data_first");
        chk("drop_no_instr_yet", 64'(bus.instr_mem_resp), 64'd0);
        bus.data_read = 0;
        wait_pulse(1'b0, "drop_instr_second");
        bus.instr_read = 0;
        @(negedge clk);

        // Reset in the middle of a data access with no memory response
        mem_hold = 1;
        bus.data_mem_address = 32'h20; bus.data_read = 1;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_pmem_read", 64'(bus.pmem_read), 64'd0);
        chk("arst_pmem_address", 64'(bus.pmem_address), 64'd0);
        chk("arst_data_resp", 64'(bus.data_mem_resp), 64'd0);
        chk("arst_data_rdata", 64'(bus.data_mem_rdata), 64'd0);
        chk("arst_instr_rdata", 64'(bus.instr_mem_rdata), 64'd0);
        chk("arst_pmem_wdata", bus.pmem_wdata, 64'd0);
        chk("arst_byte_en", 64'(bus.pmem_byte_en), 64'd0);
        bus.data_read = 0; mem_hold = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_wait = 0; mem_word = 64'h0123_4567_89AB_CDEF;
        bus.instr_mem_address = 32'h1000; bus.instr_read = 1;
        @(negedge clk);
        chk("post_rst_pmem_read", 64'(bus.pmem_read), 64'd1);
        chk("post_rst_address", 64'(bus.pmem_address), 64'h1000);
        @(negedge clk);
        chk("post_rst_resp", 64'(bus.instr_mem_resp), 64'd1);
        chk("post_rst_rdata", 64'(bus.instr_mem_rdata), 64'h89AB_CDEF);
        bus.instr_read = 0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
